pc_adder: RTL and testbench

- Next-sequential-PC generator for the 32-bit processor datapath; sits between the ProgramCounter output and the PC-source mux.
- Computes PCAddResult = PCResult + 4 combinationally, so same-cycle fetch sees it with no clock edge.
- Also provides a registered copy plus wrap and alignment status for the pipeline/debug logic.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/pc_adder.sv | 55 +++++
 tb/tb_pc_adder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Datapath-wide constants shared by the processor front end.
package cpu_pkg;

    localparam int unsigned WORD_WIDTH  = 32;
    localparam int unsigned INSTR_BYTES = 4;

endpackage : cpu_pkg

// File: rtl/pc_adder.sv
// Next-sequential-PC adder: combinational PC+INCR with carry-out and alignment flag,
// plus an enabled, asynchronously cleared register copy of the sum and carry.
module pc_adder
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH,
    parameter int unsigned INCR  = INSTR_BYTES
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             Wrap,
    output logic             Misaligned,
    output logic [WIDTH-1:0] PCAddResultReg,
    output logic             WrapReg
);

    // One extra bit so the carry-out of the increment is kept as Wrap.
    logic [WIDTH:0] sum_full;

    logic [WIDTH-1:0] pc_add_result_reg_d;
    logic [WIDTH-1:0] pc_add_result_reg_q;
    logic             wrap_reg_d;
    logic             wrap_reg_q;

    assign sum_full    = {1'b0, PCResult} + (WIDTH+1)'(INCR);
    assign PCAddResult = sum_full[WIDTH-1:0];
    assign Wrap        = sum_full[WIDTH];
    assign Misaligned  = (PCResult[1:0] != 2'b00);

    always_comb begin
        pc_add_result_reg_d = pc_add_result_reg_q;
        wrap_reg_d          = wrap_reg_q;
        if (En) begin
            pc_add_result_reg_d = sum_full[WIDTH-1:0];
            wrap_reg_d          = sum_full[WIDTH];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_add_result_reg_q <= '0;
            wrap_reg_q          <= 1'b0;
        end else begin
            pc_add_result_reg_q <= pc_add_result_reg_d;
            wrap_reg_q          <= wrap_reg_d;
        end
    end

    assign PCAddResultReg = pc_add_result_reg_q;
    assign WrapReg        = wrap_reg_q;

endmodule : pc_adder

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: vector table plus scoreboard queues for the
// combinational and registered outputs.
module tb_pc_adder;

    logic        Clk;
    logic        Reset_n;
    logic        En;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        Wrap;
    logic        Misaligned;
    logic [31:0] PCAddResultReg;
    logic        WrapReg;

    int total;
    int bad;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] sum;
        logic        wrap;
        logic        mis;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] sum;
        logic        wrap;
        logic        mis;
    } comb_exp_t;

    typedef struct {
        string       nm;
        logic [31:0] sum;
        logic        wrap;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];
    vec_t      vecs[6];

    pc_adder #(
        .WIDTH (32),
        .INCR  (4)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .En             (En),
        .PCResult       (PCResult),
        .PCAddResult    (PCAddResult),
        .Wrap           (Wrap),
        .Misaligned     (Misaligned),
        .PCAddResultReg (PCAddResultReg),
        .WrapReg        (WrapReg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_comb(input string nm, input logic [31:0] pc);
        comb_exp_t e;
        logic [32:0] s;
        s      = {1'b0, pc} + 33'd4;
        e.nm   = nm;
        e.sum  = s[31:0];
        e.wrap = s[32];
        e.mis  = (pc[1:0] != 2'b00);
        comb_q.push_back(e);
    endtask

    task automatic pop_comb();
        comb_exp_t e;
        if (comb_q.size() == 0) begin
            chk("comb_q_empty", 32'd1, 32'd0);
            return;
        end
        e = comb_q.pop_front();
        chk({e.nm, ".sum"}, PCAddResult, e.sum);
        chk({e.nm, ".wrap"}, {31'd0, Wrap}, {31'd0, e.wrap});
        chk({e.nm, ".mis"}, {31'd0, Misaligned}, {31'd0, e.mis});
    endtask

    task automatic pop_reg();
        reg_exp_t e;
        if (reg_q.size() == 0) begin
            chk("reg_q_empty", 32'd1, 32'd0);
            return;
        end
        e = reg_q.pop_front();
        chk({e.nm, ".sumreg"}, PCAddResultReg, e.sum);
        chk({e.nm, ".wrapreg"}, {31'd0, WrapReg}, {31'd0, e.wrap});
    endtask

    initial begin
        reg_exp_t r;
        total = 0;
        bad   = 0;

        vecs[0] = '{"v_0007", 32'h0000_0007, 32'h0000_000B, 1'b0, 1'b1};
        vecs[1] = '{"v_03E8", 32'h0000_03E8, 32'h0000_03EC, 1'b0, 1'b0};
        vecs[2] = '{"v_FFFF0000", 32'hFFFF_0000, 32'hFFFF_0004, 1'b0, 1'b0};
        vecs[3] = '{"v_0112", 32'h0000_0112, 32'h0000_0116, 1'b0, 1'b1};
        vecs[4] = '{"v_wrapFC", 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{"v_wrapFD", 32'hFFFF_FFFD, 32'h0000_0001, 1'b1, 1'b1};

        // Reset state, including comb path live during reset
        Reset_n  = 1'b0;
        En       = 1'b0;
        PCResult = 32'h0000_0100;
        #1;
        r = '{"reset_init", 32'h0, 1'b0};
        reg_q.push_back(r);
        pop_reg();
        push_comb("comb_in_reset", PCResult);
        pop_comb();

        @(negedge Clk);
        Reset_n = 1'b1;

        // Table sweep, En=0
        for (int i = 0; i < 6; i++) begin
            PCResult = vecs[i].pc;
            comb_q.push_back('{vecs[i].nm, vecs[i].sum, vecs[i].wrap, vecs[i].mis});
            #20;
            pop_comb();
        end
        r = '{"hold_en0_sweep", 32'h0, 1'b0};
        reg_q.push_back(r);
        pop_reg();

        // Random comb values against an arithmetic model
        for (int i = 0; i < 8; i++) begin
            PCResult = (i < 2) ? (32'hFFFF_FFFC + 32'(i + 2)) : $urandom;
            push_comb("rand", PCResult);
            #20;
            pop_comb();
        end

        // Register capture then hold
        @(negedge Clk);
        En = 1'b1;
        PCResult = 32'h0040_0000;
        reg_q.push_back('{"cap_400000", 32'h0040_0004, 1'b0});
        @(posedge Clk); #1;
        pop_reg();

        @(negedge Clk);
        En = 1'b0;
        PCResult = 32'h0040_0004;
        reg_q.push_back('{"hold_400004", 32'h0040_0004, 1'b0});
        @(posedge Clk); #1;
        pop_reg();
        push_comb("comb_400004", PCResult);
        pop_comb();

        // Registered wrap, then mid-cycle async reset
        @(negedge Clk);
        En = 1'b1;
        PCResult = 32'hFFFF_FFFC;
        reg_q.push_back('{"cap_wrap", 32'h0000_0000, 1'b1});
        @(posedge Clk); #1;
        pop_reg();
        #2;
        Reset_n = 1'b0;
        #1;
        reg_q.push_back('{"async_rst_wrap", 32'h0, 1'b0});
        pop_reg();
        push_comb("comb_during_rst", PCResult);
        pop_comb();

        // Reset holds through edges even with En=1
        @(posedge Clk); #1;
        reg_q.push_back('{"rst_hold_edge", 32'h0, 1'b0});
        pop_reg();

        // Release, capture nonzero, then async clear between edges
        @(negedge Clk);
        Reset_n = 1'b1;
        PCResult = 32'h0000_1000;
        reg_q.push_back('{"cap_1000", 32'h0000_1004, 1'b0});
        @(posedge Clk); #1;
        pop_reg();
        #3;
        Reset_n = 1'b0;
        #1;
        reg_q.push_back('{"async_rst_1004", 32'h0, 1'b0});
        pop_reg();

        @(negedge Clk);
        Reset_n = 1'b1;
        En = 1'b0;
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_pc_adder
